// File: rtl/alu_sequencer.sv
// Serial instruction sequencer driving an external combinational ALU.
// Ports: instr_valid/instr_ready/instr in, alu_* out, alu_result in, wb_* out, halted/illegal, dbg read.
module alu_sequencer #(
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  output logic [WIDTH_DATA-1:0] alu_operand_a,
  output logic [WIDTH_DATA-1:0] alu_operand_b,
  output logic [4:0]            alu_op_code,
  input  logic [WIDTH_DATA-1:0] alu_result,
  output logic                  wb_valid,
  output logic [2:0]            wb_addr,
  output logic [WIDTH_DATA-1:0] wb_data,
  output logic                  halted,
  output logic                  illegal,
  input  logic [2:0]            dbg_addr,
  output logic [WIDTH_DATA-1:0] dbg_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_LOADI = 5'd1;
  localparam logic [4:0] OP_MOV   = 5'd2;
  localparam logic [4:0] OP_HALT  = 5'd3;
  localparam logic [4:0] OP_ALU_LO = 5'd4;
  localparam logic [4:0] OP_ALU_HI = 5'd13;

  typedef struct packed {
    logic [4:0]            op;
    logic [2:0]            rd;
    logic [15:0]           imm;
    logic [WIDTH_DATA-1:0] a;
    logic [WIDTH_DATA-1:0] b;
  } id_ex_t;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  id_ex_t                ex;
  logic [WIDTH_DATA-1:0] res;
  logic [WIDTH_DATA-1:0] rf [0:7];

  logic [4:0]            in_op;
  logic [2:0]            in_rd;
  logic [2:0]            in_rs1;
  logic [2:0]            in_rs2;
  logic [15:0]           in_imm;
  logic [WIDTH_DATA-1:0] src_a;
  logic [WIDTH_DATA-1:0] src_b;
  logic                  unused_bits;

  logic                  accept;
  logic                  ex_alu;
  logic                  ex_wr;
  logic                  ex_halt;
  logic                  ex_ill;
  logic [WIDTH_DATA-1:0] wb_val;
  logic                  do_wr;

  assign in_op  = instr[31:27];
  assign in_rd  = instr[26:24];
  assign in_rs1 = instr[23:21];
  assign in_rs2 = instr[20:18];
  assign in_imm = instr[15:0];
  assign unused_bits = ^instr[17:16];

  // r0 is hardwired; rf[0] is never written
  assign src_a = (in_rs1 == 3'd0) ? '0 : rf[in_rs1];
  assign src_b = (in_rs2 == 3'd0) ? '0 : rf[in_rs2];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

  assign instr_ready = (state == S_IDLE);
  assign accept = instr_valid & instr_ready;

  // operation classes of the captured instruction
  always_comb begin
    ex_alu  = 1'b0;
    ex_wr   = 1'b0;
    ex_halt = 1'b0;
    ex_ill  = 1'b0;
    unique case (1'b1)
      (ex.op == OP_NOP): begin
      end
      (ex.op == OP_LOADI),
      (ex.op == OP_MOV): begin
        ex_wr = 1'b1;
      end
      (ex.op == OP_HALT): begin
        ex_halt = 1'b1;
      end
      (ex.op >= OP_ALU_LO && ex.op <= OP_ALU_HI): begin
        ex_alu = 1'b1;
        ex_wr  = 1'b1;
      end
      default: begin
        ex_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    wb_val = res;
    unique case (1'b1)
      (ex.op == OP_LOADI): begin
        wb_val = {{(WIDTH_DATA-16){1'b0}}, ex.imm};
      end
      (ex.op == OP_MOV): begin
        wb_val = ex.a;
      end
      default: begin
        wb_val = res;
      end
    endcase
  end

  // ALU is only presented with operands while a real ALU op executes
  always_comb begin
    alu_op_code   = '0;
    alu_operand_a = '0;
    alu_operand_b = '0;
    if (state == S_EXEC && ex_alu) begin
      alu_op_code   = ex.op;
      alu_operand_a = ex.a;
      alu_operand_b = ex.b;
    end
  end

  // a reset in WB suppresses the write, so hide the pulse too
  assign do_wr    = (state == S_WB) && ex_wr && !rst;
  assign wb_valid = do_wr;
  assign wb_addr  = do_wr ? ex.rd : 3'd0;
  assign wb_data  = do_wr ? wb_val : '0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_WB;
      end
      S_WB: begin
        state_nxt = ex_halt ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_WB && ex_halt) halted <= 1'b1;
      if (state == S_WB && ex_ill) illegal <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      res <= '0;
    end else begin
      if (accept) begin
        ex.op  <= in_op;
        ex.rd  <= in_rd;
        ex.imm <= in_imm;
        ex.a   <= src_a;
        ex.b   <= src_b;
      end
      if (state == S_EXEC) res <= alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (do_wr && ex.rd != 3'd0) begin
      rf[ex.rd] <= wb_val;
    end
  end

endmodule
